// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage data-memory access unit. It runs a req/ack handshake,
//            stalls the pipeline front and registers the MEM/WB payload.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inWord,
  input  logic              inRegWrite,
  input  logic [DATA_W-1:0] inResult,
  input  logic [DATA_W-1:0] inStoreData,
  input  logic [RD_W-1:0]   inRd,
  output logic              stall,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic [3:0]        memByteEn,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData,
  output logic [DATA_W-1:0] outWbData,
  output logic [RD_W-1:0]   outRd,
  output logic              outRegWrite,
  output logic              outMisaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic              w_access;
  logic              w_isStore;
  logic              w_misaligned;
  logic              w_start;
  logic [1:0]        r_lane;
  logic              r_word;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_loadData;

  // A simultaneous read and write is handled as a load.
  assign w_access     = inMemRead | inMemWrite;
  assign w_isStore    = inMemWrite & ~inMemRead;
  assign w_misaligned = inWord & (inResult[1:0] != 2'b00);
  assign w_start      = w_access & ~w_misaligned;

  assign w_byte     = r_rdata[{r_lane, 3'b000} +: 8];
  assign w_loadData = r_word ? r_rdata : {{(DATA_W-8){w_byte[7]}}, w_byte};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_nextState = S_WAIT;
          stall       = 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (memAck) w_nextState = S_DONE;
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memReq        <= 1'b0;
      memWe         <= 1'b0;
      memAddr       <= '0;
      memWData      <= '0;
      memByteEn     <= 4'b0000;
      r_lane        <= 2'b00;
      r_word        <= 1'b0;
      r_rdata       <= '0;
      outWbData     <= '0;
      outRd         <= '0;
      outRegWrite   <= 1'b0;
      outMisaligned <= 1'b0;
    end else begin
      outMisaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_access) begin
            outWbData   <= inResult;
            outRd       <= inRd;
            outRegWrite <= inRegWrite;
          end else if (w_misaligned) begin
            outMisaligned <= 1'b1;
            outRegWrite   <= 1'b0;
          end else begin
            memReq      <= 1'b1;
            memWe       <= w_isStore;
            memAddr     <= {inResult[DATA_W-1:2], 2'b00};
            memWData    <= inWord ? inStoreData : {4{inStoreData[7:0]}};
            memByteEn   <= inWord ? 4'b1111 : (4'b0001 << inResult[1:0]);
            r_lane      <= inResult[1:0];
            r_word      <= inWord;
            outRegWrite <= 1'b0;
          end
        end
        S_WAIT: begin
          outRegWrite <= 1'b0;
          if (memAck) begin
            memReq  <= 1'b0;
            r_rdata <= memRData;
          end
        end
        S_DONE: begin
          // EX/MEM still holds the instruction that made the access.
          outWbData   <= memWe ? inResult : w_loadData;
          outRd       <= inRd;
          outRegWrite <= inRegWrite & ~w_isStore;
        end
        default: outRegWrite <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed and randomized bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        inMemRead, inMemWrite, inWord, inRegWrite;
  logic [31:0] inResult, inStoreData;
  logic [4:0]  inRd;
  logic        stall, memReq, memWe, memAck;
  logic [31:0] memAddr, memWData, memRData, outWbData;
  logic [3:0]  memByteEn;
  logic [4:0]  outRd;
  logic        outRegWrite, outMisaligned;

  int nPass  = 0;
  int nTotal = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.DATA_W(32), .RD_W(5)) dut (
    .clock(clock), .reset(reset),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inWord(inWord),
    .inRegWrite(inRegWrite), .inResult(inResult), .inStoreData(inStoreData),
    .inRd(inRd), .stall(stall), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .memByteEn(memByteEn),
    .memAck(memAck), .memRData(memRData), .outWbData(outWbData),
    .outRd(outRd), .outRegWrite(outRegWrite), .outMisaligned(outMisaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clearInputs();
    inMemRead = 0; inMemWrite = 0; inWord = 0; inRegWrite = 0;
    inResult = 0; inStoreData = 0; inRd = 0;
  endtask

  // Reference: what the register file should receive for a load.
  function automatic logic [31:0] refLoad(input bit word, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int b;
    if (word) return rdata;
    b = int'((rdata >> (8 * (addr % 4))) & 32'd255);
    return (b >= 128) ? 32'(b - 256) : 32'(b);
  endfunction

  task automatic doAlu(input logic [31:0] result, input logic [4:0] rd, input bit rw);
    @(negedge clock);
    inRegWrite = rw; inResult = result; inRd = rd;
    #1;
    check("alu_stall", 32'(stall), 0);
    check("alu_req", 32'(memReq), 0);
    @(negedge clock);
    check("alu_wb", outWbData, result);
    check("alu_rd", 32'(outRd), 32'(rd));
    check("alu_rw", 32'(outRegWrite), 32'(rw));
    clearInputs();
  endtask

  task automatic doMem(input bit isStore, input bit word, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd,
                       input int ackDelay, input logic [31:0] rdata);
    logic [31:0] expAddr, expBe, expWd, expWb;
    expAddr = addr - (addr % 4);
    expBe   = word ? 32'd15 : (32'd1 << (addr % 4));
    expWd   = word ? sdata : (sdata & 32'hFF) * 32'h01010101;
    expWb   = isStore ? addr : refLoad(word, addr, rdata);
    @(negedge clock);
    inMemRead = !isStore; inMemWrite = isStore; inWord = word; inRegWrite = 1;
    inResult = addr; inStoreData = sdata; inRd = rd;
    #1;
    if (word && (addr % 4) != 0) begin
      check("mis_stall", 32'(stall), 0);
      @(negedge clock);
      check("mis_pulse", 32'(outMisaligned), 1);
      check("mis_req", 32'(memReq), 0);
      check("mis_rw", 32'(outRegWrite), 0);
      clearInputs();
      @(negedge clock);
      check("mis_once", 32'(outMisaligned), 0);
      check("mis_req2", 32'(memReq), 0);
    end else begin
      check("idle_stall", 32'(stall), 1);
      check("idle_req", 32'(memReq), 0);
      @(negedge clock);
      check("req_we", 32'(memWe), 32'(isStore));
      check("req_be", 32'(memByteEn), expBe);
      if (isStore) check("req_wdata", memWData, expWd);
      check("bubble_rw", 32'(outRegWrite), 0);
      for (int i = 0; i <= ackDelay; i++) begin
        check("wait_stall", 32'(stall), 1);
        check("wait_req", 32'(memReq), 1);
        check("wait_addr", memAddr, expAddr);
        if (i == ackDelay) begin
          memAck = 1; memRData = rdata;
        end
        @(negedge clock);
        memAck = 0; memRData = $urandom;
      end
      check("done_stall", 32'(stall), 0);
      check("done_req", 32'(memReq), 0);
      @(negedge clock);
      check("wb_data", outWbData, expWb);
      check("wb_rd", 32'(outRd), 32'(rd));
      check("wb_rw", 32'(outRegWrite), 32'(!isStore));
      clearInputs();
    end
  endtask

  initial begin
    reset = 1; memAck = 0; memRData = 0;
    clearInputs();
    repeat (2) @(negedge clock);
    check("rst_req", 32'(memReq), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_wb", outWbData, 0);
    check("rst_be", 32'(memByteEn), 0);
    check("rst_rw", 32'(outRegWrite), 0);
    reset = 0;

    doAlu(32'h1234, 5'd7, 1'b1);
    doMem(1'b0, 1'b1, 32'h40, 32'h0, 5'd9, 1, 32'hDEADBEEF);
    doMem(1'b0, 1'b0, 32'h43, 32'h0, 5'd1, 0, 32'h80FF0000);
    doMem(1'b0, 1'b0, 32'h42, 32'h0, 5'd2, 0, 32'h80FF0000);
    doMem(1'b0, 1'b0, 32'h41, 32'h0, 5'd3, 2, 32'h00007F00);
    doMem(1'b1, 1'b0, 32'h102, 32'hAB, 5'd4, 0, 32'h0);
    doMem(1'b1, 1'b1, 32'h205, 32'h11223344, 5'd5, 0, 32'h0);

    // Reset in the middle of an outstanding request, then a stray ack.
    @(negedge clock);
    inMemRead = 1; inWord = 1; inRegWrite = 1; inResult = 32'h80; inRd = 5'd6;
    @(negedge clock);
    check("pre_rst_req", 32'(memReq), 1);
    #2 reset = 1;
    #1;
    check("midrst_req", 32'(memReq), 0);
    check("midrst_stall", 32'(stall), 0);
    check("midrst_addr", memAddr, 0);
    check("midrst_we", 32'(memWe), 0);
    @(negedge clock);
    clearInputs();
    reset = 0;
    @(negedge clock);
    memAck = 1; memRData = 32'hCAFEF00D;
    @(negedge clock);
    memAck = 0;
    check("stray_req", 32'(memReq), 0);
    check("stray_stall", 32'(stall), 0);
    check("stray_rw", 32'(outRegWrite), 0);
    doMem(1'b0, 1'b1, 32'h84, 32'h0, 5'd3, 0, 32'h13579BDF);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 5));
      a = $urandom & 32'h0000FFFF;
      case (kind)
        0: doAlu($urandom, 5'($urandom), 1'($urandom));
        1: doMem(1'b0, 1'b1, a & ~32'd3, 0, 5'($urandom), int'($urandom_range(0, 3)), $urandom);
        2: doMem(1'b0, 1'b0, a, 0, 5'($urandom), int'($urandom_range(0, 3)), $urandom);
        3: doMem(1'b1, 1'b0, a, $urandom, 5'($urandom), int'($urandom_range(0, 3)), 0);
        4: doMem(1'b1, 1'b1, a & ~32'd3, $urandom, 5'($urandom), int'($urandom_range(0, 3)), 0);
        default: doMem(1'($urandom), 1'b1, a | 32'd1, $urandom, 5'($urandom), 0, 0);
      endcase
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire
